// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte intake and registered serial line.
// Define UART_TX_FIFO_EN to replace the single holding register with a 4-entry FIFO.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 722,
  parameter bit          LSB_FIRST    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 14;
  localparam int unsigned IDX_W  = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic              push;
  logic              pop;
  logic              buf_empty;
  logic [DATA_W-1:0] buf_head;
  logic              ready_q, ready_d;

  assign push    = i_valid & ready_q;
  assign o_ready = ready_q;

`ifdef UART_TX_FIFO_EN
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned OCC_W  = 3;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;

  // Pointers wrap naturally at 2 bits; ready depends only on the next occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + OCC_W'(push) - OCC_W'(pop);
    ready_d  = (count_d != OCC_W'(DEPTH));
  end

  assign buf_empty = (count_q == '0);
  assign buf_head  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) mem_q[wr_ptr_q] <= i_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end
`else
  logic              full_q, full_d;
  logic [DATA_W-1:0] hold_q;

  // A push only happens while empty, so push and pop never coincide here.
  always_comb begin
    full_d  = push | (full_q & ~pop);
    ready_d = ~full_d;
  end

  assign buf_empty = ~full_q;
  assign buf_head  = hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      hold_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push) hold_q <= i_data;
      full_q  <= full_d;
      ready_q <= ready_d;
    end
  end
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  function automatic logic sel_bit(input logic [DATA_W-1:0] b, input logic [IDX_W-1:0] i);
    return LSB_FIRST ? b[i] : b[IDX_LAST - i];
  endfunction

  // Next-state logic; outputs are derived from the next state so the line is registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!buf_empty) begin
          pop     = 1'b1;
          shift_d = buf_head;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) state_d = S_STOP;
          else                   idx_d   = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!buf_empty) begin
            pop     = 1'b1;
            shift_d = buf_head;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = sel_bit(shift_d, idx_d);
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_tx   = tx_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: two instances (722 clk/bit LSB-first, 6 clk/bit MSB-first).
module tb_uart_tx;

  localparam int CPB_A    = 722;
  localparam int CPB_B    = 6;
  localparam int NRAND    = 24;
  localparam int WAIT_MAX = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_n, val, rdy, tx, busy, done;
  logic [1:0][7:0] dat;
  int              checks = 0;
  int              errors = 0;
  logic [7:0]      q[$];

  typedef struct {
    int         k;
    logic [7:0] b;
    logic [9:0] pat;
  } vec_t;
  vec_t vecs[5];

  uart_tx #(.CLKS_PER_BIT(CPB_A), .LSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n[0]), .i_data(dat[0]), .i_valid(val[0]),
    .o_ready(rdy[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0]));

  uart_tx #(.CLKS_PER_BIT(CPB_B), .LSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n[1]), .i_data(dat[1]), .i_valid(val[1]),
    .o_ready(rdy[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1]));

  function automatic int cpb(input int k);
    return (k == 0) ? CPB_A : CPB_B;
  endfunction

  // Line level per bit slot: start 0, eight data bits in chosen order, stop 1.
  function automatic logic [9:0] model_pat(input bit lsb, input logic [7:0] b);
    logic [9:0] p;
    p    = '0;
    p[9] = 1'b1;
    for (int s = 1; s <= 8; s++) p[s] = lsb ? b[s-1] : b[8-s];
    return p;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Call on a negedge; returns on the negedge after the handshake edge.
  task automatic push(input int k, input logic [7:0] b);
    int n;
    n      = 0;
    val[k] = 1'b1;
    dat[k] = b;
    while (rdy[k] !== 1'b1 && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready_timeout", (n < WAIT_MAX) ? 1 : 0, 1);
    q.push_back(b);
    @(negedge clk);
    val[k] = 1'b0;
    dat[k] = 8'($urandom);
  endtask

  task automatic wait_low(input int k, output int ok);
    int n;
    n = 0;
    while (tx[k] !== 1'b0 && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    ok = (n < WAIT_MAX) ? 1 : 0;
    chk("start_bit_timeout", ok, 1);
  endtask

  // Current negedge must be the first cycle of the frame; returns on its last cycle.
  task automatic check_frame(input int k, input logic [9:0] pat, input string tag);
    int c, s, ndone, done_at, nbusy;
    int nbad[10];
    c = cpb(k);
    ndone = 0; done_at = -1; nbusy = 0;
    for (int j = 0; j < 10; j++) nbad[j] = 0;
    for (int i = 0; i < 10 * c; i++) begin
      if (i > 0) @(negedge clk);
      s = i / c;
      if (tx[k] !== pat[s]) nbad[s]++;
      if (done[k] === 1'b1) begin ndone++; done_at = i + 1; end
      if (busy[k] !== 1'b1) nbusy++;
    end
    for (int j = 0; j < 10; j++) chk($sformatf("%s slot%0d bad_cycles", tag, j), nbad[j], 0);
    chk($sformatf("%s done_count", tag), ndone, 1);
    chk($sformatf("%s done_cycle", tag), done_at, 10 * c);
    chk($sformatf("%s busy_low_cycles", tag), nbusy, 0);
  endtask

  int         ok, n, gap, idle_bad;
  logic [7:0] rb, cb;

  initial begin
    vecs[0] = '{0, 8'h55, 10'b1010101010};
    vecs[1] = '{1, 8'h80, 10'b1000000010};
    vecs[2] = '{1, 8'hA3, 10'b1110001010};
    vecs[3] = '{1, 8'h01, 10'b1100000000};
    vecs[4] = '{1, 8'h0F, 10'b1111100000};

    rst_n = 2'b00;
    val   = 2'b00;
    dat   = '0;
    #23;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset tx%0d", k),    tx[k],   1);
      chk($sformatf("reset ready%0d", k), rdy[k],  1);
      chk($sformatf("reset busy%0d", k),  busy[k], 0);
      chk($sformatf("reset done%0d", k),  done[k], 0);
    end
    @(negedge clk);
    rst_n = 2'b11;
    repeat (2) @(negedge clk);

    // Single frames from the table
    for (int i = 0; i < 5; i++) begin
      push(vecs[i].k, vecs[i].b);
      chk($sformatf("tbl%0d idle_before_start", i), tx[vecs[i].k], 1);
      @(negedge clk);
      check_frame(vecs[i].k, vecs[i].pat, $sformatf("tbl%0d", i));
      @(negedge clk);
      chk($sformatf("tbl%0d busy_after", i), busy[vecs[i].k], 0);
      chk($sformatf("tbl%0d tx_after", i),   tx[vecs[i].k],   1);
    end

    // Back-to-back frames with valid held high
    val[0] = 1'b1;
    dat[0] = 8'hA3;
    @(negedge clk);
    dat[0] = 8'h3C;
`ifndef UART_TX_FIFO_EN
    chk("b2b ready_stall", rdy[0], 0);
`endif
    chk("b2b idle_before_start", tx[0], 1);
    fork
      begin
        @(negedge clk);
        check_frame(0, 10'b1101000110, "b2b_A3");
        @(negedge clk);
        check_frame(0, 10'b1001111000, "b2b_3C");
      end
      begin
        n = 0;
        while (rdy[0] !== 1'b1 && n < WAIT_MAX) begin
          @(negedge clk);
          n++;
        end
`ifndef UART_TX_FIFO_EN
        chk("b2b ready_rise_after_pop", n, 1);
`endif
        @(negedge clk);
        val[0] = 1'b0;
      end
    join
    @(negedge clk);
    chk("b2b busy_after", busy[0], 0);

    // Randomized stream against the queue model
    q.delete();
    fork
      begin
        for (int i = 0; i < NRAND; i++) begin
          gap = $urandom_range(0, 12 * CPB_B);
          repeat (gap) begin
            @(negedge clk);
            dat[1] = 8'($urandom);
          end
          rb = 8'($urandom);
          push(1, rb);
        end
      end
      begin
        for (int i = 0; i < NRAND; i++) begin
          wait_low(1, ok);
          if (ok == 0) break;
          chk("rand queue_nonempty", (q.size() > 0) ? 1 : 0, 1);
          if (q.size() == 0) break;
          cb = q.pop_front();
          check_frame(1, model_pat(1'b0, cb), $sformatf("rand%0d_%02h", i, cb));
          @(negedge clk);
        end
      end
    join

`ifdef UART_TX_FIFO_EN
    q.delete();
    fork
      begin
        for (int i = 1; i <= 5; i++) push(1, 8'(i));
        chk("fifo ready_low_when_full", rdy[1], 0);
      end
      begin
        wait_low(1, ok);
        for (int i = 1; i <= 5; i++) begin
          if (i > 1) @(negedge clk);
          check_frame(1, model_pat(1'b0, 8'(i)), $sformatf("fifo%0d", i));
        end
      end
    join
    @(negedge clk);
`endif

    // Reset in data bit 3 with a second byte buffered
    repeat (3) @(negedge clk);
    push(1, 8'hFF);
    push(1, 8'h33);
    repeat (4 * CPB_B + 1) @(negedge clk);
    chk("mid busy_before_reset", busy[1], 1);
`ifndef UART_TX_FIFO_EN
    chk("mid ready_before_reset", rdy[1], 0);
`endif
    #2 rst_n[1] = 1'b0;
    #1;
    chk("mid tx_in_reset",    tx[1],   1);
    chk("mid busy_in_reset",  busy[1], 0);
    chk("mid ready_in_reset", rdy[1],  1);
    chk("mid done_in_reset",  done[1], 0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(negedge clk);

    // Reset during the start bit must release the line at once
    push(1, 8'h5A);
    @(negedge clk);
    chk("start tx_low_before_reset", tx[1], 0);
    #2 rst_n[1] = 1'b0;
    #1;
    chk("start tx_high_in_reset", tx[1], 1);
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(negedge clk);

    push(1, 8'h0F);
    chk("post idle_before_start", tx[1], 1);
    @(negedge clk);
    check_frame(1, 10'b1111100000, "post_0F");
    idle_bad = 0;
    repeat (12 * CPB_B) begin
      @(negedge clk);
      if (tx[1] !== 1'b1 || busy[1] !== 1'b0) idle_bad++;
    end
    chk("post no_residue_cycles", idle_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
